// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: chooses sequential / JAL / branch-redirect / hold each cycle,
// drives the icache read port and tags the returned word as valid or squashed for decode.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_re,
  output logic [31:0] icache_addr,
  input  logic        icache_stall,
  input  logic        pipe_stall,
  input  logic        dec_jump,
  input  logic [31:0] dec_target,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic        flush_id
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] if_pc_nxt;
  logic        if_valid_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  logic        pend_ex, pend_ex_nxt;
  logic        redirect;
  logic [31:0] redirect_target;

  // execute-stage redirect always beats a same-cycle JAL, which is on the wrong path
  assign redirect        = ex_redirect | dec_jump;
  assign redirect_target = ex_redirect ? ex_target : dec_target;

  assign icache_re   = ~rst;
  assign icache_addr = pc;
  assign flush_id    = ex_redirect & ~rst & (state != BOOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
      pend_pc  <= 32'h0;
      pend_ex  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      if_pc    <= if_pc_nxt;
      if_valid <= if_valid_nxt;
      pend_pc  <= pend_pc_nxt;
      pend_ex  <= pend_ex_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    if_pc_nxt    = if_pc;
    if_valid_nxt = if_valid;
    pend_pc_nxt  = pend_pc;
    pend_ex_nxt  = pend_ex;

    case (state)
      BOOT: begin
        if (!icache_stall) begin
          state_nxt    = RUN;
          pc_nxt       = pc + 32'd4;
          if_pc_nxt    = pc;
          if_valid_nxt = 1'b1;
        end
      end

      RUN, WAIT: begin
        if (icache_stall) begin
          // icache cannot take a new address, so a redirect has to be parked
          if_valid_nxt = 1'b0;
          if (redirect) begin
            state_nxt   = PEND;
            pend_pc_nxt = redirect_target;
            pend_ex_nxt = ex_redirect;
          end else begin
            state_nxt = WAIT;
          end
        end else begin
          state_nxt = RUN;
          if (redirect) begin
            pc_nxt       = redirect_target;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b0;
          end else if (!pipe_stall) begin
            pc_nxt       = pc + 32'd4;
            if_pc_nxt    = pc;
            if_valid_nxt = 1'b1;
          end
        end
      end

      PEND: begin
        if_valid_nxt = 1'b0;
        // a pending branch target is never displaced by a younger JAL
        if (ex_redirect) begin
          pend_pc_nxt = ex_target;
          pend_ex_nxt = 1'b1;
        end else if (dec_jump && !pend_ex) begin
          pend_pc_nxt = dec_target;
        end
        if (!icache_stall) begin
          state_nxt   = RUN;
          pc_nxt      = pend_pc_nxt;
          if_pc_nxt   = pc;
          pend_ex_nxt = 1'b0;
        end
      end

      default: state_nxt = BOOT;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: reset release, JAL, branch redirect, stall/pend,
// pipeline hold, address wrap and reset during a pending redirect.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_re;
  logic [31:0] icache_addr;
  logic        icache_stall;
  logic        pipe_stall;
  logic        dec_jump;
  logic [31:0] dec_target;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        flush_id;

  int tests  = 0;
  int fails  = 0;
  int bubbles = 0;
  logic seen_300 = 1'b0;
  logic seen_500 = 1'b0;
  logic seen_0c0 = 1'b0;

  pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_re    (icache_re),
    .icache_addr  (icache_addr),
    .icache_stall (icache_stall),
    .pipe_stall   (pipe_stall),
    .dec_jump     (dec_jump),
    .dec_target   (dec_target),
    .ex_redirect  (ex_redirect),
    .ex_target    (ex_target),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .flush_id     (flush_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (icache_re && icache_addr == 32'h4000_0300) seen_300 = 1'b1;
    if (icache_re && icache_addr == 32'h4000_0500) seen_500 = 1'b1;
    if (icache_re && icache_addr == 32'h4000_00C0) seen_0c0 = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; icache_stall = 1'b0; pipe_stall = 1'b0;
    dec_jump = 1'b0; dec_target = '0; ex_redirect = 1'b1; ex_target = 32'h4000_0900;

    // in reset: outputs at reset values, flush masked
    step();
    @(negedge clk);
    check_eq("rst_re",     {31'b0, icache_re}, 32'd0);
    check_eq("rst_flush",  {31'b0, flush_id},  32'd0);
    check_eq("rst_addr",   icache_addr, RST_PC);
    check_eq("rst_if_pc",  if_pc, RST_PC);
    check_eq("rst_valid",  {31'b0, if_valid},  32'd0);
    ex_redirect = 1'b0;

    // BOOT cycle
    step(); rst = 1'b0;
    @(negedge clk);
    check_eq("boot_re",    {31'b0, icache_re}, 32'd1);
    check_eq("boot_addr",  icache_addr, RST_PC);
    check_eq("boot_valid", {31'b0, if_valid},  32'd0);

    step(); @(negedge clk);
    check_eq("seq_addr1",  icache_addr, 32'h4000_0004);
    check_eq("first_valid",{31'b0, if_valid},  32'd1);
    check_eq("first_pc",   if_pc, RST_PC);

    // JAL: no flush, one bubble
    step(); dec_jump = 1'b1; dec_target = 32'h4000_0100;
    @(negedge clk);
    check_eq("seq_addr2",  icache_addr, 32'h4000_0008);
    check_eq("jal_flush",  {31'b0, flush_id},  32'd0);

    step(); dec_jump = 1'b0;
    @(negedge clk);
    check_eq("jal_addr",   icache_addr, 32'h4000_0100);
    check_eq("jal_bubble", {31'b0, if_valid},  32'd0);

    // simultaneous branch redirect and JAL
    step(); ex_redirect = 1'b1; ex_target = 32'h4000_0200; dec_jump = 1'b1; dec_target = 32'h4000_0300;
    @(negedge clk);
    check_eq("jal_valid",  {31'b0, if_valid},  32'd1);
    check_eq("jal_if_pc",  if_pc, 32'h4000_0100);
    check_eq("jal_next",   icache_addr, 32'h4000_0104);
    check_eq("both_flush", {31'b0, flush_id},  32'd1);

    step(); ex_redirect = 1'b0; dec_jump = 1'b0;
    @(negedge clk);
    check_eq("both_addr",  icache_addr, 32'h4000_0200);
    check_eq("both_bubble",{31'b0, if_valid},  32'd0);
    check_eq("both_noflush",{31'b0, flush_id}, 32'd0);

    // icache stall 3 cycles: JAL in 1st, branch in 2nd, younger JAL in 3rd
    step(); icache_stall = 1'b1; dec_jump = 1'b1; dec_target = 32'h4000_0040;
    @(negedge clk);
    check_eq("br_if_pc",   if_pc, 32'h4000_0200);
    check_eq("br_valid",   {31'b0, if_valid},  32'd1);

    step(); dec_jump = 1'b0; ex_redirect = 1'b1; ex_target = 32'h4000_0080;
    @(negedge clk);
    check_eq("stl_flush",  {31'b0, flush_id},  32'd1);
    check_eq("stl_hold1",  icache_addr, 32'h4000_0204);
    if (!if_valid) bubbles++;

    step(); ex_redirect = 1'b0; dec_jump = 1'b1; dec_target = 32'h4000_00C0;
    @(negedge clk);
    check_eq("stl_hold2",  icache_addr, 32'h4000_0204);
    if (!if_valid) bubbles++;

    step(); dec_jump = 1'b0; icache_stall = 1'b0;
    @(negedge clk);
    if (!if_valid) bubbles++;

    step(); @(negedge clk);
    check_eq("pend_issue", icache_addr, 32'h4000_0080);
    if (!if_valid) bubbles++;

    step(); pipe_stall = 1'b1;
    @(negedge clk);
    check_eq("pend_bubbles", bubbles, 32'd4);
    check_eq("pend_valid", {31'b0, if_valid},  32'd1);
    check_eq("pend_if_pc", if_pc, 32'h4000_0080);

    // pipeline hold for one cycle
    step(); pipe_stall = 1'b0;
    @(negedge clk);
    check_eq("ps_addr",    icache_addr, 32'h4000_0084);
    check_eq("ps_valid",   {31'b0, if_valid},  32'd1);
    check_eq("ps_if_pc",   if_pc, 32'h4000_0080);
    check_eq("ps_re",      {31'b0, icache_re}, 32'd1);

    step(); ex_redirect = 1'b1; ex_target = 32'hFFFF_FFFC;
    @(negedge clk);
    check_eq("ps_resume",  if_pc, 32'h4000_0084);

    // wrap at top of address space
    step(); ex_redirect = 1'b0;
    @(negedge clk);
    check_eq("wrap_pre",   icache_addr, 32'hFFFF_FFFC);

    step(); icache_stall = 1'b1; ex_redirect = 1'b1; ex_target = 32'h4000_0500;
    @(negedge clk);
    check_eq("wrap_addr",  icache_addr, 32'h0000_0000);
    check_eq("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // reset while a redirect is pending
    step(); ex_redirect = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("prst_re",    {31'b0, icache_re}, 32'd0);

    step(); rst = 1'b0;
    @(negedge clk);
    check_eq("prst_addr",  icache_addr, RST_PC);
    check_eq("prst_valid", {31'b0, if_valid},  32'd0);
    check_eq("prst_if_pc", if_pc, RST_PC);

    // BOOT holds while icache stalled
    step(); icache_stall = 1'b0;
    @(negedge clk);
    check_eq("boot_stall_addr",  icache_addr, RST_PC);
    check_eq("boot_stall_valid", {31'b0, if_valid}, 32'd0);

    step(); @(negedge clk);
    check_eq("reboot_addr",  icache_addr, 32'h4000_0004);
    check_eq("reboot_valid", {31'b0, if_valid}, 32'd1);
    check_eq("reboot_if_pc", if_pc, RST_PC);

    repeat (3) step();
    @(negedge clk);
    check_eq("never_300", {31'b0, seen_300}, 32'd0);
    check_eq("never_500", {31'b0, seen_500}, 32'd0);
    check_eq("never_0c0", {31'b0, seen_0c0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
